fp_exec_ctrl: RTL and testbench
===============================

Name: fp_exec_ctrl

Overview:
- Sequencing controller for the multi-cycle floating-point unit in the EX stage of the 5-stage integer/FP pipeline.
- When an FP instruction reaches EX, it pulses the FP unit's start and holds the pipeline (IF, ID, ID_EX frozen; bubble into EX_MEM) until the unit signals completion.
- It latches the FP result and releases the instruction for exactly one cycle.
- It bounds the wait with a timeout, so a hung FP unit cannot deadlock the core, and keeps op and stall-cycle performance counters.

Parameters:
TIMEOUT, 31, max cycles spent in WAIT before forced completion (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
IsFpE  in  1  FP instruction present in EX
FpOpE  in  2  FP opcode of EX instruction (00 add, 01 sub, 10 mul, 11 div)
fp_valid_i  in  1  FP unit result valid
fp_result_i  in  32  FP unit result
fp_start_o  out  1  one-cycle start pulse to FP unit
fp_op_o  out  2  opcode to FP unit, held stable during operation
stall_o  out  1  freeze IF/ID/ID_EX and clear EX_MEM input
fp_done_o  out  1  FP instruction may leave EX this cycle
fp_result_o  out  32  latched FP result, feeds EX result mux
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky: a timeout has occurred
fp_ops_o  out  CNT_W  completed FP ops, wraps
stall_cycles_o  out  CNT_W  cycles with stall_o=1, wraps

Behaviour:
- Interface: clock is clk; reset is asynchronous active-high.
- Reset (async, immediate): state=IDLE, op_q=0, wait_cnt=0, fp_result_o=0, timeout_o=0, both perf counters=0.
- All combinational outputs evaluate to 0 under reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If IsFpE=1: fp_start_o=1, stall_o=1 (combinational, same cycle), fp_op_o=FpOpE.
  - On the same edge: op_q<=FpOpE, wait_cnt<=0, next state WAIT.
  - Otherwise all control outputs are 0 and fp_op_o=op_q.
- WAIT:
  - stall_o=1, fp_start_o=0, fp_op_o=op_q, wait_cnt increments each cycle.
  - If fp_valid_i=1: fp_result_o<=fp_result_i, next state DONE.
  - Else if wait_cnt==TIMEOUT-1: fp_result_o<=32'h7FC00000 (canonical quiet NaN), timeout_o<=1, next state DONE.
  - fp_valid_i takes priority over timeout in the same cycle.
- DONE:
  - stall_o=0, fp_done_o=1 for exactly one cycle; the instruction moves to MEM at the closing edge. Next state IDLE unconditionally.
  - The next FP instruction is evaluated in IDLE one cycle later. Back-to-back FP ops therefore cost one IDLE cycle minimum, with no re-issue of the retired op.
- fp_valid_i is ignored in IDLE and DONE; a spurious valid never changes fp_result_o.
- Latency: FP instruction entering EX at cycle 0 with unit valid at cycle k (k>=1):
  - stall_o=1 for cycles 0..k.
  - fp_done_o=1 at cycle k+1.
  - Total EX occupancy k+2 cycles.
- fp_result_o holds its value until the next capture.
- Performance counters:
  - fp_ops_o increments on each DONE cycle.
  - stall_cycles_o increments on each cycle stall_o=1.
  - Both wrap modulo 2^CNT_W.
- timeout_o is cleared only by reset.
- Reset during WAIT: state returns to IDLE asynchronously and stall_o drops at once. An in-flight FP result arriving afterwards is ignored.
- FlushE/FlushD have no effect on this block. The EX instruction is the oldest in flight and is never flushed by a branch.
- wait_cnt width: clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Shared package fp_ctrl_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2)
  - FP opcode constants FP_ADD/FP_SUB/FP_MUL/FP_DIV
  - FP_CANON_NAN=32'h7FC00000
- One sub-module, perf_counter (parameter CNT_W, inputs clk, reset, inc; output count), instantiated twice.
- The FSM, wait counter and result latch stay in fp_exec_ctrl.

Test Plan:
1. IsFpE=1, FpOpE=10 at cycle 0, fp_valid_i=1 with fp_result_i=32'h40490FDB at cycle 3 -> fp_start_o=1 only at cycle 0; stall_o=1 cycles 0-3; fp_done_o=1 at cycle 4; fp_result_o=32'h40490FDB; fp_ops_o=1; stall_cycles_o=4.
2. FP op issued, fp_valid_i never asserted, TIMEOUT=31 -> stall_o=1 for 32 cycles; fp_done_o at cycle 32; fp_result_o=32'h7FC00000; timeout_o=1 and stays 1 through later normal ops.
3. Two consecutive FP ops in EX (IsFpE held, valid at cycle 2 each) -> starts at cycles 0 and 4; done at cycles 3 and 7; fp_ops_o=2; exactly two start pulses.
4. Reset asserted mid-WAIT (cycle 2), then fp_valid_i=1 at cycle 4 after release -> stall_o=0 immediately; busy_o=0; fp_result_o=0; no fp_done_o.
5. fp_valid_i=1 with data 32'h3F800000 while IDLE and IsFpE=0 -> fp_result_o unchanged; no state change; counters unchanged.
6. fp_valid_i=1 on the same cycle wait_cnt reaches TIMEOUT-1 -> real result captured; timeout_o remains 0.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared state encoding and FP constants for the EX-stage FP controller
package fp_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_SUB = 2'b01;
  localparam logic [1:0] FP_MUL = 2'b10;
  localparam logic [1:0] FP_DIV = 2'b11;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter with async active-high reset
module perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
endmodule

// File: rtl/fp_exec_ctrl.sv
// fp_exec_ctrl: sequences the multi-cycle FP unit in EX, stalling the pipe until result or timeout
module fp_exec_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IsFpE,
  input  logic [1:0]       FpOpE,
  input  logic             fp_valid_i,
  input  logic [31:0]      fp_result_i,
  output logic             fp_start_o,
  output logic [1:0]       fp_op_o,
  output logic             stall_o,
  output logic             fp_done_o,
  output logic [31:0]      fp_result_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] fp_ops_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  state_t state;
  logic [1:0] opQ;
  logic [WW-1:0] waitCnt;
  logic issue;
  // Reset gating keeps every combinational output low while reset is held
  assign issue = !reset && state == IDLE && IsFpE;
  assign fp_start_o = issue;
  assign stall_o = issue || (!reset && state == WAIT);
  assign fp_done_o = !reset && state == DONE;
  assign busy_o = !reset && state != IDLE;
  assign fp_op_o = reset ? 2'b00 : issue ? FpOpE : opQ;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      opQ <= '0;
      waitCnt <= '0;
      fp_result_o <= '0;
      timeout_o <= 1'b0;
    end else
      case (state)
        IDLE: if (IsFpE) begin
          opQ <= FpOpE;
          waitCnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          waitCnt <= waitCnt + WW'(1);
          if (fp_valid_i) begin
            fp_result_o <= fp_result_i;
            state <= DONE;
          end else if (waitCnt == LAST) begin
            fp_result_o <= FP_CANON_NAN;
            timeout_o <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
  perf_counter #(.CNT_W(CNT_W)) opsCnt (.clk(clk), .reset(reset), .inc(fp_done_o), .count(fp_ops_o));
  perf_counter #(.CNT_W(CNT_W)) stallCnt (.clk(clk), .reset(reset), .inc(stall_o), .count(stall_cycles_o));
endmodule

// File: tb/tb_fp_exec_ctrl.sv
// tb_fp_exec_ctrl: directed self-checking bench for fp_exec_ctrl
module tb_fp_exec_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic IsFpE;
  logic [1:0] FpOpE;
  logic fp_valid_i;
  logic [31:0] fp_result_i;
  logic fp_start_o, stall_o, fp_done_o, busy_o, timeout_o;
  logic [1:0] fp_op_o;
  logic [31:0] fp_result_o;
  logic [15:0] fp_ops_o, stall_cycles_o;
  int checks = 0;
  int errors = 0;
  int starts = 0;

  fp_exec_ctrl #(.TIMEOUT(31), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .IsFpE(IsFpE), .FpOpE(FpOpE),
    .fp_valid_i(fp_valid_i), .fp_result_i(fp_result_i),
    .fp_start_o(fp_start_o), .fp_op_o(fp_op_o), .stall_o(stall_o),
    .fp_done_o(fp_done_o), .fp_result_o(fp_result_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .fp_ops_o(fp_ops_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, sample shortly after
  task automatic cyc(input logic f, input logic [1:0] op, input logic v, input logic [31:0] r);
    @(negedge clk);
    IsFpE = f; FpOpE = op; fp_valid_i = v; fp_result_i = r;
    #1;
    starts += int'(fp_start_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; IsFpE = 1'b1; FpOpE = 2'b11; fp_valid_i = 1'b0; fp_result_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", 32'(fp_start_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_op", 32'(fp_op_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_result", fp_result_o, 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_ops", 32'(fp_ops_o), 0);
    chk("rst_stallcyc", 32'(stall_cycles_o), 0);
    @(negedge clk);
    reset = 1'b0; IsFpE = 1'b0;
    // Spurious valid while idle
    cyc(0, 0, 1, 32'h3F800000);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_stall", 32'(stall_o), 0);
    cyc(0, 0, 0, 0);
    chk("t5_result", fp_result_o, 0);
    chk("t5_busy2", 32'(busy_o), 0);
    chk("t5_ops", 32'(fp_ops_o), 0);
    chk("t5_stallcyc", 32'(stall_cycles_o), 0);
    // Basic MUL, valid at cycle 3
    starts = 0;
    cyc(1, 2'b10, 0, 0);
    chk("t1_c0_start", 32'(fp_start_o), 1);
    chk("t1_c0_stall", 32'(stall_o), 1);
    chk("t1_c0_op", 32'(fp_op_o), 2);
    chk("t1_c0_busy", 32'(busy_o), 0);
    for (int i = 1; i <= 2; i++) begin
      cyc(1, 2'b10, 0, 0);
      chk("t1_wait_stall", 32'(stall_o), 1);
      chk("t1_wait_busy", 32'(busy_o), 1);
      chk("t1_wait_op", 32'(fp_op_o), 2);
    end
    cyc(1, 2'b10, 1, 32'h40490FDB);
    chk("t1_c3_stall", 32'(stall_o), 1);
    chk("t1_c3_done", 32'(fp_done_o), 0);
    cyc(1, 2'b10, 0, 0);
    chk("t1_c4_done", 32'(fp_done_o), 1);
    chk("t1_c4_stall", 32'(stall_o), 0);
    chk("t1_c4_result", fp_result_o, 32'h40490FDB);
    chk("t1_c4_stallcyc", 32'(stall_cycles_o), 4);
    cyc(0, 0, 0, 0);
    chk("t1_c5_done", 32'(fp_done_o), 0);
    chk("t1_c5_ops", 32'(fp_ops_o), 1);
    chk("t1_c5_stallcyc", 32'(stall_cycles_o), 4);
    chk("t1_starts", 32'(starts), 1);
    // Valid coincides with last wait cycle: real result wins
    cyc(1, 2'b01, 0, 0);
    chk("t6_start", 32'(fp_start_o), 1);
    for (int i = 1; i <= 30; i++) begin
      cyc(1, 2'b01, 0, 0);
      chk("t6_wait_stall", 32'(stall_o), 1);
    end
    cyc(1, 2'b01, 1, 32'h41200000);
    chk("t6_c31_stall", 32'(stall_o), 1);
    cyc(1, 2'b01, 0, 0);
    chk("t6_done", 32'(fp_done_o), 1);
    chk("t6_result", fp_result_o, 32'h41200000);
    chk("t6_timeout", 32'(timeout_o), 0);
    cyc(0, 0, 0, 0);
    chk("t6_ops", 32'(fp_ops_o), 2);
    chk("t6_stallcyc", 32'(stall_cycles_o), 36);
    // Back-to-back ops with IsFpE held
    starts = 0;
    cyc(1, 2'b11, 0, 0);
    chk("t3_c0_start", 32'(fp_start_o), 1);
    cyc(1, 2'b11, 0, 0);
    chk("t3_c1_start", 32'(fp_start_o), 0);
    cyc(1, 2'b11, 1, 32'h11111111);
    cyc(1, 2'b11, 0, 0);
    chk("t3_c3_done", 32'(fp_done_o), 1);
    chk("t3_c3_start", 32'(fp_start_o), 0);
    chk("t3_c3_result", fp_result_o, 32'h11111111);
    cyc(1, 2'b00, 0, 0);
    chk("t3_c4_start", 32'(fp_start_o), 1);
    chk("t3_c4_op", 32'(fp_op_o), 0);
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 1, 32'h22222222);
    cyc(1, 2'b00, 0, 0);
    chk("t3_c7_done", 32'(fp_done_o), 1);
    chk("t3_c7_result", fp_result_o, 32'h22222222);
    cyc(0, 0, 0, 0);
    chk("t3_starts", 32'(starts), 2);
    chk("t3_ops", 32'(fp_ops_o), 4);
    chk("t3_stallcyc", 32'(stall_cycles_o), 42);
    // Hung unit: timeout after 32 stall cycles
    cyc(1, 2'b10, 0, 0);
    chk("t2_start", 32'(fp_start_o), 1);
    for (int i = 1; i <= 31; i++) begin
      cyc(1, 2'b10, 0, 0);
      chk("t2_wait_stall", 32'(stall_o), 1);
      chk("t2_wait_done", 32'(fp_done_o), 0);
    end
    cyc(1, 2'b10, 0, 0);
    chk("t2_done", 32'(fp_done_o), 1);
    chk("t2_stall", 32'(stall_o), 0);
    chk("t2_result", fp_result_o, 32'h7FC00000);
    chk("t2_timeout", 32'(timeout_o), 1);
    cyc(0, 0, 1, 32'hDEADBEEF);
    chk("t2_stallcyc", 32'(stall_cycles_o), 74);
    chk("t2_ops", 32'(fp_ops_o), 5);
    chk("t2_spurious", fp_result_o, 32'h7FC00000);
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 1, 32'h3F800000);
    cyc(1, 2'b00, 0, 0);
    chk("t2_n_done", 32'(fp_done_o), 1);
    chk("t2_n_result", fp_result_o, 32'h3F800000);
    chk("t2_n_timeout", 32'(timeout_o), 1);
    cyc(0, 0, 0, 0);
    chk("t2_n_ops", 32'(fp_ops_o), 6);
    chk("t2_n_stallcyc", 32'(stall_cycles_o), 76);
    chk("t2_sticky", 32'(timeout_o), 1);
    // Reset in the middle of WAIT
    cyc(1, 2'b01, 0, 0);
    cyc(1, 2'b01, 0, 0);
    chk("t4_c1_stall", 32'(stall_o), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t4_stall", 32'(stall_o), 0);
    chk("t4_busy", 32'(busy_o), 0);
    chk("t4_result", fp_result_o, 0);
    chk("t4_done", 32'(fp_done_o), 0);
    chk("t4_timeout", 32'(timeout_o), 0);
    chk("t4_ops", 32'(fp_ops_o), 0);
    @(negedge clk);
    reset = 1'b0; IsFpE = 1'b0;
    cyc(0, 0, 1, 32'h12345678);
    chk("t4_late_result", fp_result_o, 0);
    chk("t4_late_busy", 32'(busy_o), 0);
    cyc(0, 0, 0, 0);
    chk("t4_late_result2", fp_result_o, 0);
    chk("t4_late_done", 32'(fp_done_o), 0);
    chk("t4_late_stallcyc", 32'(stall_cycles_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
